// File: rtl/ui_to_tilelink_bridge.sv
// MIG-style UI slave port bridged to a TileLink-UL master.
// Each 128-bit UI access becomes up to four 32-bit TL transactions.
module ui_to_tilelink_bridge #(
   parameter int TL_RS     = 4,
   parameter int TL_AW     = 28,
   parameter int SOURCE_ID = 0
) (
   input  logic             tilelink_clock_i,
   input  logic             tilelink_reset_i,
   input  logic [2:0]       app_cmd,
   input  logic [TL_AW-1:0] app_addr,
   input  logic             app_en,
   output logic             app_rdy,
   input  logic [127:0]     app_wdf_data,
   input  logic [15:0]      app_wdf_mask,
   input  logic             app_wdf_wren,
   input  logic             app_wdf_end,
   output logic             app_wdf_rdy,
   output logic [127:0]     app_rd_data,
   output logic             app_rd_data_valid,
   output logic             app_rd_data_end,
   output logic [2:0]       tl_a_opcode,
   output logic [2:0]       tl_a_param,
   output logic [3:0]       tl_a_size,
   output logic [TL_RS-1:0] tl_a_source,
   output logic [TL_AW-1:0] tl_a_address,
   output logic [3:0]       tl_a_mask,
   output logic [31:0]      tl_a_data,
   output logic             tl_a_corrupt,
   output logic             tl_a_valid,
   input  logic             tl_a_ready,
   input  logic [2:0]       tl_d_opcode,
   input  logic [1:0]       tl_d_param,
   input  logic [3:0]       tl_d_size,
   input  logic [TL_RS-1:0] tl_d_source,
   input  logic             tl_d_denied,
   input  logic [31:0]      tl_d_data,
   input  logic             tl_d_corrupt,
   input  logic             tl_d_valid,
   output logic             tl_d_ready,
   output logic             err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_WDF,
      S_ISSUE,
      S_RESP,
      S_RDATA
   } state_t;

   state_t            r_state;
   logic              r_run;
   logic [TL_AW-5:0]  r_base;
   logic              r_rd;
   logic [1:0]        r_k;
   logic              r_wdf_full;
   logic [127:0]      r_wdf_data;
   logic [15:0]       r_wdf_mask;
   logic [127:0]      r_rdata;
   logic              r_err;

   logic              w_cmd_take;
   logic              w_wdf_take;
   logic              w_found;
   logic [1:0]        w_sel;
   logic [3:0]        w_avail;
   logic [3:0]        w_a_mask;
   logic              w_d_bad;
   logic              w_unused;

   assign app_rdy           = r_run && (r_state == S_IDLE);
   assign app_wdf_rdy       = r_run && !r_wdf_full;
   assign w_cmd_take        = app_en && app_rdy;
   assign w_wdf_take        = app_wdf_wren && app_wdf_rdy;
   assign w_d_bad           = tl_d_denied || tl_d_corrupt;

   // Reads never skip; writes skip words whose bytes are all masked off.
   always_comb begin
      w_avail = 4'b0000;
      w_found = 1'b0;
      w_sel   = r_k;
      for (int j = 0; j < 4; j++) begin
         w_avail[j] = r_rd || (r_wdf_mask[4*j +: 4] != 4'hF);
      end
      for (int j = 3; j >= 0; j--) begin
         if (j >= int'(r_k) && w_avail[j]) begin
            w_found = 1'b1;
            w_sel   = 2'(j);
         end
      end
   end

   assign w_a_mask = r_rd ? 4'hF : ~r_wdf_mask[{w_sel, 2'b00} +: 4];

   assign tl_a_valid   = (r_state == S_ISSUE) && w_found;
   assign tl_a_address = {r_base, w_sel, 2'b00};
   assign tl_a_size    = 4'd2;
   assign tl_a_param   = 3'd0;
   assign tl_a_corrupt = 1'b0;
   assign tl_a_source  = TL_RS'(SOURCE_ID);
   assign tl_a_mask    = w_a_mask;
   assign tl_a_opcode  = r_rd ? 3'd4 : ((w_a_mask == 4'hF) ? 3'd0 : 3'd1);
   assign tl_a_data    = r_rd ? 32'd0 : r_wdf_data[{w_sel, 5'd0} +: 32];

   assign tl_d_ready        = (r_state == S_RESP);
   assign app_rd_data_valid = (r_state == S_RDATA);
   assign app_rd_data_end   = (r_state == S_RDATA);
   assign app_rd_data       = r_rdata;
   assign err_o             = r_err;

   assign w_unused = ^{app_cmd[2:1], app_addr[3:0], app_wdf_end,
                       tl_d_opcode, tl_d_param, tl_d_size, tl_d_source};

   always_ff @(posedge tilelink_clock_i) begin
      if (!tilelink_reset_i) begin
         r_state    <= S_IDLE;
         r_run      <= 1'b0;
         r_base     <= '0;
         r_rd       <= 1'b0;
         r_k        <= 2'd0;
         r_wdf_full <= 1'b0;
         r_wdf_data <= '0;
         r_wdf_mask <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (w_wdf_take) begin
            r_wdf_full <= 1'b1;
            r_wdf_data <= app_wdf_data;
            r_wdf_mask <= app_wdf_mask;
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_cmd_take) begin
                  r_base <= app_addr[TL_AW-1:4];
                  r_rd   <= app_cmd[0];
                  r_k    <= 2'd0;
                  if (app_cmd[0] || r_wdf_full || w_wdf_take)
                     r_state <= S_ISSUE;
                  else
                     r_state <= S_WAIT_WDF;
               end
            end
            S_WAIT_WDF: begin
               if (r_wdf_full || w_wdf_take)
                  r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (!w_found) begin
                  r_wdf_full <= 1'b0;
                  r_state    <= S_IDLE;
               end else if (tl_a_ready) begin
                  r_k     <= w_sel;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (tl_d_valid) begin
                  if (r_rd)
                     r_rdata[{r_k, 5'd0} +: 32] <= w_d_bad ? 32'd0 : tl_d_data;
                  if (w_d_bad)
                     r_err <= 1'b1;
                  if (r_k == 2'd3) begin
                     if (r_rd) begin
                        r_state <= S_RDATA;
                     end else begin
                        r_wdf_full <= 1'b0;
                        r_state    <= S_IDLE;
                     end
                  end else begin
                     r_k     <= r_k + 2'd1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_RDATA: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ui_to_tilelink_bridge.sv
// Directed bench for ui_to_tilelink_bridge with a hand-driven TL slave.
// Expected values are written out by hand from the intended behaviour.
module tb_ui_to_tilelink_bridge;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    app_cmd = 3'd0;
   logic [27:0]   app_addr = '0;
   logic          app_en = 1'b0;
   logic          app_rdy;
   logic [127:0]  app_wdf_data = '0;
   logic [15:0]   app_wdf_mask = '0;
   logic          app_wdf_wren = 1'b0;
   logic          app_wdf_end = 1'b0;
   logic          app_wdf_rdy;
   logic [127:0]  app_rd_data;
   logic          app_rd_data_valid;
   logic          app_rd_data_end;
   logic [2:0]    tl_a_opcode;
   logic [2:0]    tl_a_param;
   logic [3:0]    tl_a_size;
   logic [3:0]    tl_a_source;
   logic [27:0]   tl_a_address;
   logic [3:0]    tl_a_mask;
   logic [31:0]   tl_a_data;
   logic          tl_a_corrupt;
   logic          tl_a_valid;
   logic          tl_a_ready = 1'b0;
   logic [2:0]    tl_d_opcode = 3'd0;
   logic [1:0]    tl_d_param = 2'd0;
   logic [3:0]    tl_d_size = 4'd2;
   logic [3:0]    tl_d_source = 4'd0;
   logic          tl_d_denied = 1'b0;
   logic [31:0]   tl_d_data = '0;
   logic          tl_d_corrupt = 1'b0;
   logic          tl_d_valid = 1'b0;
   logic          tl_d_ready;
   logic          err_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int a_beats = 0;
   int rdv_count = 0;
   int snap = 0;

   ui_to_tilelink_bridge dut (
      .tilelink_clock_i (clk),
      .tilelink_reset_i (rst_n),
      .app_cmd          (app_cmd),
      .app_addr         (app_addr),
      .app_en           (app_en),
      .app_rdy          (app_rdy),
      .app_wdf_data     (app_wdf_data),
      .app_wdf_mask     (app_wdf_mask),
      .app_wdf_wren     (app_wdf_wren),
      .app_wdf_end      (app_wdf_end),
      .app_wdf_rdy      (app_wdf_rdy),
      .app_rd_data      (app_rd_data),
      .app_rd_data_valid(app_rd_data_valid),
      .app_rd_data_end  (app_rd_data_end),
      .tl_a_opcode      (tl_a_opcode),
      .tl_a_param       (tl_a_param),
      .tl_a_size        (tl_a_size),
      .tl_a_source      (tl_a_source),
      .tl_a_address     (tl_a_address),
      .tl_a_mask        (tl_a_mask),
      .tl_a_data        (tl_a_data),
      .tl_a_corrupt     (tl_a_corrupt),
      .tl_a_valid       (tl_a_valid),
      .tl_a_ready       (tl_a_ready),
      .tl_d_opcode      (tl_d_opcode),
      .tl_d_param       (tl_d_param),
      .tl_d_size        (tl_d_size),
      .tl_d_source      (tl_d_source),
      .tl_d_denied      (tl_d_denied),
      .tl_d_data        (tl_d_data),
      .tl_d_corrupt     (tl_d_corrupt),
      .tl_d_valid       (tl_d_valid),
      .tl_d_ready       (tl_d_ready),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tl_a_valid && tl_a_ready) a_beats <= a_beats + 1;
      if (app_rd_data_valid) rdv_count <= rdv_count + 1;
   end

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input bit rd, input logic [27:0] addr, input bit with_wdf,
                      input logic [127:0] d, input logic [15:0] m);
      check("cmd_rdy", app_rdy, 1);
      app_en = 1'b1;
      app_cmd = {2'b00, rd};
      app_addr = addr;
      if (with_wdf) begin
         app_wdf_wren = 1'b1;
         app_wdf_end = 1'b1;
         app_wdf_data = d;
         app_wdf_mask = m;
      end
      @(posedge clk);
      @(negedge clk);
      app_en = 1'b0;
      app_wdf_wren = 1'b0;
      app_wdf_end = 1'b0;
      t0 = cyc;
   endtask

   task automatic wdf(input logic [127:0] d, input logic [15:0] m);
      check("wdf_rdy", app_wdf_rdy, 1);
      app_wdf_wren = 1'b1;
      app_wdf_end = 1'b1;
      app_wdf_data = d;
      app_wdf_mask = m;
      @(posedge clk);
      @(negedge clk);
      app_wdf_wren = 1'b0;
      app_wdf_end = 1'b0;
      check("wdf_full", app_wdf_rdy, 0);
   endtask

   task automatic do_a(input logic [27:0] addr, input logic [2:0] op,
                       input logic [3:0] m, input logic [31:0] d, input int hold);
      for (int i = 0; i < 40 && !tl_a_valid; i++) @(negedge clk);
      check("a_valid", tl_a_valid, 1);
      check("a_addr", tl_a_address, addr);
      check("a_opcode", tl_a_opcode, op);
      check("a_mask", tl_a_mask, m);
      check("a_data", tl_a_data, d);
      check("a_misc", {tl_a_size, tl_a_param, tl_a_source, tl_a_corrupt},
            {4'd2, 3'd0, 4'd0, 1'b0});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("a_hold",
               {tl_a_valid, tl_a_address, tl_a_opcode, tl_a_mask, tl_a_data},
               {1'b1, addr, op, m, d});
      end
      tl_a_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tl_a_ready = 1'b0;
   endtask

   task automatic do_d(input logic [31:0] d, input bit den, input int dly);
      for (int i = 0; i < 40 && !tl_d_ready; i++) @(negedge clk);
      check("d_ready", tl_d_ready, 1);
      repeat (dly) @(negedge clk);
      if (dly > 0) check("d_ready_wait", {tl_d_ready, tl_a_valid}, 2'b10);
      tl_d_valid = 1'b1;
      tl_d_data = d;
      tl_d_denied = den;
      @(posedge clk);
      @(negedge clk);
      tl_d_valid = 1'b0;
      tl_d_denied = 1'b0;
   endtask

   task automatic wait_rd(input logic [127:0] exp, input int exp_lat);
      for (int i = 0; i < 60 && !app_rd_data_valid; i++) @(negedge clk);
      check("rd_valid", app_rd_data_valid, 1);
      check("rd_end", app_rd_data_end, 1);
      check("rd_data", app_rd_data, exp);
      if (exp_lat >= 0) check("rd_latency", 32'(cyc - t0), 32'(exp_lat));
      @(negedge clk);
      check("rd_pulse_one", {app_rd_data_valid, app_rd_data_end}, 2'b00);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_outputs",
            {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
             tl_a_valid, tl_d_ready, err_o}, 7'd0);
      check("rst_rd_data", app_rd_data, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rdy", {app_rdy, app_wdf_rdy}, 2'b11);

      // read 0x120, no stalls
      cmd(1'b1, 28'h0000120, 1'b0, '0, '0);
      do_a(28'h120, 3'd4, 4'hF, 32'd0, 0); do_d(32'h11, 1'b0, 0);
      do_a(28'h124, 3'd4, 4'hF, 32'd0, 0); do_d(32'h22, 1'b0, 0);
      do_a(28'h128, 3'd4, 4'hF, 32'd0, 0); do_d(32'h33, 1'b0, 0);
      do_a(28'h12C, 3'd4, 4'hF, 32'd0, 0); do_d(32'h44, 1'b0, 0);
      wait_rd(128'h00000044_00000033_00000022_00000011, 8);
      check("err_clean", err_o, 0);

      // full write, data before command
      wdf(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'h0000);
      cmd(1'b0, 28'h0000040, 1'b0, '0, '0);
      do_a(28'h40, 3'd0, 4'hF, 32'hAAAAAAAA, 0); do_d(32'd0, 1'b0, 0);
      do_a(28'h44, 3'd0, 4'hF, 32'hBBBBBBBB, 0); do_d(32'd0, 1'b0, 0);
      do_a(28'h48, 3'd0, 4'hF, 32'hCCCCCCCC, 0); do_d(32'd0, 1'b0, 0);
      do_a(28'h4C, 3'd0, 4'hF, 32'hDDDDDDDD, 0); do_d(32'd0, 1'b0, 0);
      check("wr_done_rdy", {app_rdy, app_wdf_rdy}, 2'b11);

      // mask FF0F with command and data together: only word 1
      snap = a_beats;
      cmd(1'b0, 28'h0000080, 1'b1,
          128'h44444444_33333333_22222222_11111111, 16'hFF0F);
      do_a(28'h84, 3'd0, 4'hF, 32'h22222222, 0); do_d(32'd0, 1'b0, 0);
      repeat (3) @(negedge clk);
      check("ff0f_beats", 32'(a_beats - snap), 32'd1);
      check("ff0f_idle", {app_rdy, app_wdf_rdy, tl_a_valid}, 3'b110);

      // fully masked write, data after command: no TL traffic
      snap = a_beats;
      cmd(1'b0, 28'h00000C0, 1'b0, '0, '0);
      wdf(128'h1, 16'hFFFF);
      @(negedge clk);
      check("ffff_idle", {app_rdy, app_wdf_rdy}, 2'b11);
      repeat (4) @(negedge clk);
      check("ffff_beats", 32'(a_beats - snap), 32'd0);

      // partial write on word 3 only
      snap = a_beats;
      cmd(1'b0, 28'h00001F0, 1'b1,
          128'h12345678_00000000_00000000_00000000, 16'h5FFF);
      do_a(28'h1FC, 3'd1, 4'hA, 32'h12345678, 0); do_d(32'd0, 1'b0, 0);
      repeat (2) @(negedge clk);
      check("partial_beats", 32'(a_beats - snap), 32'd1);
      check("partial_idle", app_rdy, 1);

      // read with A stalls and delayed D
      snap = a_beats;
      cmd(1'b1, 28'h0000207, 1'b0, '0, '0);
      do_a(28'h200, 3'd4, 4'hF, 32'd0, 5); do_d(32'hA1, 1'b0, 7);
      do_a(28'h204, 3'd4, 4'hF, 32'd0, 0); do_d(32'hB2, 1'b0, 0);
      do_a(28'h208, 3'd4, 4'hF, 32'd0, 5); do_d(32'hC3, 1'b0, 7);
      do_a(28'h20C, 3'd4, 4'hF, 32'd0, 0); do_d(32'hD4, 1'b0, 0);
      wait_rd(128'h000000D4_000000C3_000000B2_000000A1, -1);
      check("stall_beats", 32'(a_beats - snap), 32'd4);

      // denied word 2
      cmd(1'b1, 28'h0000300, 1'b0, '0, '0);
      do_a(28'h300, 3'd4, 4'hF, 32'd0, 0); do_d(32'h5, 1'b0, 0);
      do_a(28'h304, 3'd4, 4'hF, 32'd0, 0); do_d(32'h6, 1'b0, 0);
      do_a(28'h308, 3'd4, 4'hF, 32'd0, 0); do_d(32'h7, 1'b1, 0);
      do_a(28'h30C, 3'd4, 4'hF, 32'd0, 0); do_d(32'h8, 1'b0, 0);
      wait_rd(128'h00000008_00000000_00000006_00000005, -1);
      check("err_set", err_o, 1);

      cmd(1'b1, 28'h0000310, 1'b0, '0, '0);
      do_a(28'h310, 3'd4, 4'hF, 32'd0, 0); do_d(32'h9, 1'b0, 0);
      do_a(28'h314, 3'd4, 4'hF, 32'd0, 0); do_d(32'hA, 1'b0, 0);
      do_a(28'h318, 3'd4, 4'hF, 32'd0, 0); do_d(32'hB, 1'b0, 0);
      do_a(28'h31C, 3'd4, 4'hF, 32'd0, 0); do_d(32'hC, 1'b0, 0);
      wait_rd(128'h0000000C_0000000B_0000000A_00000009, -1);
      check("err_sticky", err_o, 1);

      // reset during RESP of a read
      snap = rdv_count;
      cmd(1'b1, 28'h0000400, 1'b0, '0, '0);
      do_a(28'h400, 3'd4, 4'hF, 32'd0, 0);
      check("mid_resp", tl_d_ready, 1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_outs", {app_rdy, tl_d_ready, tl_a_valid, err_o}, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_rdy", {app_rdy, app_wdf_rdy}, 2'b11);
      repeat (12) @(negedge clk);
      check("no_rd_pulse", 32'(rdv_count - snap), 32'd0);
      check("rel_quiet", {tl_a_valid, tl_d_ready, app_rd_data_valid}, 3'b000);
      check("rel_rd_data", app_rd_data, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
